// File: rtl/signal_wave_gen_pkg.sv
`default_nettype none
// ============================================================================
//  dds_pkg
//  Shape encodings, default widths and elaboration-time helpers shared by
//  the signal_wave_gen DDS generator, its ROM and its bus interface.
//  Revision: 1.0
// ============================================================================
package dds_pkg;

  localparam logic [1:0] SHAPE_SINE = 2'd0;
  localparam logic [1:0] SHAPE_TRI  = 2'd1;
  localparam logic [1:0] SHAPE_SAW  = 2'd2;
  localparam logic [1:0] SHAPE_SQR  = 2'd3;

  localparam int DEF_PHASE_W = 32;
  localparam int DEF_ROM_AW  = 10;
  localparam int DEF_DATA_W  = 12;
  localparam int DEF_AMP_W   = 8;

  // Offset-binary midscale code for a dw-bit sample.
  function automatic int midscale(input int dw);
    return 1 << (dw - 1);
  endfunction

  // Quarter-wave sine magnitude for table entry idx:
  // round((2^(dw-1)-1) * sin(idx * (pi/2) / 2^aw)).
  // Q30 fixed-point Taylor series up to x^15, evaluated only at elaboration.
  function automatic int sine_entry(input int idx, input int aw, input int dw);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint peak;
    x    = (longint'(idx) * 64'sd1686629713) >>> aw;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k <= 7; k++) begin
      term = ((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      if (k % 2 == 1) sum = sum - term;
      else            sum = sum + term;
    end
    peak = (longint'(1) << (dw - 1)) - 1;
    return int'((sum * peak + (longint'(1) << 29)) >>> 30);
  endfunction

endpackage
`default_nettype wire

// File: rtl/signal_wave_gen_if.sv
`default_nettype none
// ============================================================================
//  signal_wave_gen_if
//  Control and sample bus of the DDS generator. The master drives phase
//  control, shape and amplitude; the slave (generator) returns samples.
//  Revision: 1.0
// ============================================================================
interface signal_wave_gen_if
  import dds_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int AMP_W   = DEF_AMP_W
) ();

  logic               en;
  logic               sync;
  logic [PHASE_W-1:0] tuning_word;
  logic [1:0]         shape;
  logic [AMP_W-1:0]   amp;
  logic [DATA_W-1:0]  value;
  logic               value_valid;
  logic               wrap;

  modport master (
    output en, sync, tuning_word, shape, amp,
    input  value, value_valid, wrap
  );

  modport slave (
    input  en, sync, tuning_word, shape, amp,
    output value, value_valid, wrap
  );

endinterface
`default_nettype wire

// File: rtl/signal_wave_gen_rom.sv
`default_nettype none
// ============================================================================
//  signal_quarter_rom
//  Quadrant-0 sine magnitude table with a registered read port. Contents are
//  constants computed at elaboration, so the table maps onto ROM / block RAM.
//  Revision: 1.0
// ============================================================================
module signal_quarter_rom
  import dds_pkg::*;
#(
  parameter int ROM_AW = DEF_ROM_AW,
  parameter int DATA_W = DEF_DATA_W
) (
  input  wire logic              clk,
  input  wire logic [ROM_AW-1:0] addr_i,
  output logic      [DATA_W-2:0] data_o
);

  logic [DATA_W-2:0] table_w [2**ROM_AW];
  logic [DATA_W-2:0] data_q;

  for (genvar gi = 0; gi < 2**ROM_AW; gi++) begin : g_table
    localparam logic [DATA_W-2:0] ENTRY = (DATA_W-1)'(sine_entry(gi, ROM_AW, DATA_W));
    assign table_w[gi] = ENTRY;
  end

  // Registered read; data carries no reset so it stays RAM-inferable.
  always_ff @(posedge clk) begin
    data_q <= table_w[addr_i];
  end

  assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/signal_wave_gen.sv
`default_nettype none
// ============================================================================
//  signal_wave_gen
//  Multi-shape DDS generator: phase accumulator, quarter-wave sine ROM,
//  computed triangle/saw/square, amplitude scaling. Shape and amplitude are
//  latched only at a phase wrap (or while idle) so changes are glitch-free.
//  Pipeline: S0 accumulate, S1 ROM read, S2 shape, S3 scale.
//  Revision: 1.0
// ============================================================================
module signal_wave_gen
  import dds_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int ROM_AW  = DEF_ROM_AW,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int AMP_W   = DEF_AMP_W
) (
  input  wire logic          clk,
  input  wire logic          rst,   // asynchronous, active-low
  signal_wave_gen_if.slave   bus
);

  localparam int                PW     = ROM_AW + 2;
  localparam logic [DATA_W-1:0] MID    = DATA_W'(midscale(DATA_W));
  localparam logic [DATA_W-1:0] MID_M1 = MID - DATA_W'(1);
  localparam int                PROD_W = DATA_W + AMP_W + 3;

  // ---------------- S0: accumulator and control latch ----------------
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic               wrap0_q, wrap0_d, vld0_q;
  logic [1:0]         shape0_q;
  logic [AMP_W-1:0]   amp0_q;
  logic [PHASE_W:0]   sum_w;
  logic               load_w;

  assign sum_w  = {1'b0, acc_q} + {1'b0, bus.tuning_word};
  // Controls may only change at a period boundary or while nothing advances.
  assign load_w = bus.sync | (bus.en & sum_w[PHASE_W]) | ~(bus.en | bus.sync);

  // Next phase: sync restarts at zero and wins over en.
  always_comb begin
    acc_d   = acc_q;
    wrap0_d = 1'b0;
    if (bus.sync) begin
      acc_d   = '0;
      wrap0_d = 1'b1;
    end else if (bus.en) begin
      acc_d   = sum_w[PHASE_W-1:0];
      wrap0_d = sum_w[PHASE_W];
    end
  end

  // Accumulator, sample qualifiers and wrap-aligned control latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      wrap0_q  <= 1'b0;
      vld0_q   <= 1'b0;
      shape0_q <= SHAPE_SINE;
      amp0_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      wrap0_q <= wrap0_d;
      vld0_q  <= bus.en | bus.sync;
      if (load_w) begin
        shape0_q <= bus.shape;
        amp0_q   <= bus.amp;
      end
    end
  end

  // ---------------- S1: ROM address and read ----------------
  logic [PW-1:0]     p_w;
  logic [ROM_AW-1:0] addr_w;
  logic [DATA_W-2:0] rom_data_w;
  logic [PW-1:0]     p1_q;
  logic [1:0]        shape1_q;
  logic [AMP_W-1:0]  amp1_q;
  logic              vld1_q, wrap1_q;

  assign p_w    = acc_q[PHASE_W-1 -: PW];
  // Odd quadrants read the table backwards to mirror quadrant 0.
  assign addr_w = p_w[ROM_AW] ? ~p_w[ROM_AW-1:0] : p_w[ROM_AW-1:0];

  signal_quarter_rom #(
    .ROM_AW (ROM_AW),
    .DATA_W (DATA_W)
  ) u_rom (
    .clk    (clk),
    .addr_i (addr_w),
    .data_o (rom_data_w)
  );

  // Phase and controls ride alongside the ROM read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_q     <= '0;
      shape1_q <= SHAPE_SINE;
      amp1_q   <= '0;
      vld1_q   <= 1'b0;
      wrap1_q  <= 1'b0;
    end else begin
      p1_q     <= p_w;
      shape1_q <= shape0_q;
      amp1_q   <= amp0_q;
      vld1_q   <= vld0_q;
      wrap1_q  <= wrap0_q;
    end
  end

  // ---------------- S2: shape generation ----------------
  logic [ROM_AW:0]   t_w;
  logic [DATA_W-2:0] tri_w;
  logic [DATA_W-1:0] saw_w;
  logic [DATA_W-1:0] s2_d, s2_q;
  logic [AMP_W-1:0]  amp2_q;
  logic              vld2_q, wrap2_q;

  assign t_w = p1_q[ROM_AW] ? ~p1_q[ROM_AW:0] : p1_q[ROM_AW:0];

  if (DATA_W - 1 > ROM_AW + 1) begin : g_tri_wide
    assign tri_w = {t_w, {(DATA_W - 2 - ROM_AW){1'b0}}};
  end else if (DATA_W - 1 == ROM_AW + 1) begin : g_tri_same
    assign tri_w = t_w;
  end else begin : g_tri_narrow
    assign tri_w = t_w[ROM_AW -: (DATA_W - 1)];
  end

  if (DATA_W > PW) begin : g_saw_wide
    assign saw_w = {p1_q, {(DATA_W - PW){1'b0}}};
  end else if (DATA_W == PW) begin : g_saw_same
    assign saw_w = p1_q;
  end else begin : g_saw_narrow
    assign saw_w = p1_q[PW-1 -: DATA_W];
  end

  // Offset-binary sample for the selected shape; q[1] selects the lower half.
  always_comb begin
    s2_d = '0;
    case (shape1_q)
      SHAPE_SINE: s2_d = p1_q[PW-1] ? (MID_M1 - {1'b0, rom_data_w}) : (MID + {1'b0, rom_data_w});
      SHAPE_TRI:  s2_d = p1_q[PW-1] ? (MID_M1 - {1'b0, tri_w})      : (MID + {1'b0, tri_w});
      SHAPE_SAW:  s2_d = saw_w;
      SHAPE_SQR:  s2_d = p1_q[PW-1] ? '0 : '1;
      default:    s2_d = '0;
    endcase
  end

  // Shaped sample register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_q    <= '0;
      amp2_q  <= '0;
      vld2_q  <= 1'b0;
      wrap2_q <= 1'b0;
    end else begin
      s2_q    <= s2_d;
      amp2_q  <= amp1_q;
      vld2_q  <= vld1_q;
      wrap2_q <= wrap1_q;
    end
  end

  // ---------------- S3: amplitude scaling ----------------
  logic signed [DATA_W:0]  diff_w;
  logic signed [AMP_W+1:0] gain_w;
  logic signed [PROD_W-1:0] prod_w;
  logic [DATA_W-1:0]       scaled_w;
  logic [DATA_W-1:0]       value_d, value_q;
  logic                    value_valid_q, wrap_q;

  assign diff_w   = $signed({1'b0, s2_q}) - $signed({1'b0, MID});
  assign gain_w   = $signed({2'b00, amp2_q}) + $signed((AMP_W + 2)'(1));
  assign prod_w   = PROD_W'(diff_w) * PROD_W'(gain_w);
  // Arithmetic shift rounds toward -inf; the result always fits in DATA_W.
  assign scaled_w = DATA_W'(prod_w >>> AMP_W);
  assign value_d  = MID + scaled_w;

  // Output register; value holds between valid samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q       <= '0;
      value_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      if (vld2_q) value_q <= value_d;
      value_valid_q <= vld2_q;
      wrap_q        <= wrap2_q;
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.wrap        = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_signal_wave_gen.sv
`default_nettype none
// ============================================================================
//  tb_signal_wave_gen
//  Directed bench for signal_wave_gen with a cycle-level reference model.
//  Revision: 1.0
// ============================================================================
module tb_signal_wave_gen;

  localparam logic [1:0] SH_SINE = 2'd0;
  localparam logic [1:0] SH_TRI  = 2'd1;
  localparam logic [1:0] SH_SAW  = 2'd2;
  localparam logic [1:0] SH_SQR  = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  signal_wave_gen_if #(.PHASE_W(32), .DATA_W(12), .AMP_W(8)) bus ();

  signal_wave_gen #(
    .PHASE_W (32),
    .ROM_AW  (10),
    .DATA_W  (12),
    .AMP_W   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_acc;
  logic [1:0]  m_shape;
  logic [7:0]  m_amp;
  int          pv [3];
  bit          pvld [3];
  bit          pw [3];
  int          m_value;
  bit          m_valid;
  bit          m_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_sample(input logic [31:0] acc, input logic [1:0] sh, input logic [7:0] a);
    int p, q, l, addr, rom, t, s, d, r;
    p    = int'(acc[31:20]);
    q    = p >> 10;
    l    = p & 1023;
    addr = ((q & 1) != 0) ? 1023 - l : l;
    rom  = int'($floor(2047.0 * $sin(real'(addr) * 3.14159265358979323846 / 2048.0) + 0.5));
    t    = ((q & 1) != 0) ? 1023 - l : l;
    case (sh)
      SH_SINE: s = ((q & 2) != 0) ? 2047 - rom : 2048 + rom;
      SH_TRI:  s = ((q & 2) != 0) ? 2047 - t   : 2048 + t;
      SH_SAW:  s = p;
      default: s = ((q & 2) != 0) ? 0 : 4095;
    endcase
    d = s - 2048;
    r = (d * (int'(a) + 1)) >>> 8;
    return (2048 + r) & 4095;
  endfunction

  task automatic model_reset();
    m_acc = '0; m_shape = SH_SINE; m_amp = '0;
    m_value = 0; m_valid = 0; m_wrap = 0;
    for (int i = 0; i < 3; i++) begin pv[i] = 0; pvld[i] = 0; pw[i] = 0; end
  endtask

  task automatic model_edge();
    logic [32:0] s;
    bit w;
    bit ld;
    m_valid = pvld[2];
    m_wrap  = pw[2];
    if (pvld[2]) m_value = pv[2];
    for (int i = 2; i > 0; i--) begin pv[i] = pv[i-1]; pvld[i] = pvld[i-1]; pw[i] = pw[i-1]; end
    s = {1'b0, m_acc} + {1'b0, bus.tuning_word};
    ld = bus.sync | (bus.en & s[32]) | (!bus.en & !bus.sync);
    if (bus.sync)    begin m_acc = '0;      w = 1'b1;  end
    else if (bus.en) begin m_acc = s[31:0]; w = s[32]; end
    else             w = 1'b0;
    if (ld) begin m_shape = bus.shape; m_amp = bus.amp; end
    pv[0]   = exp_sample(m_acc, m_shape, m_amp);
    pvld[0] = bus.en | bus.sync;
    pw[0]   = w;
  endtask

  // One clock: model follows the DUT edge, outputs compared 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    chk("model_value", 32'(bus.value), 32'(m_value));
    chk("model_valid", 32'(bus.value_valid), 32'(m_valid));
    chk("model_wrap", 32'(bus.wrap), 32'(m_wrap));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic chk_out(input string tag, input logic [11:0] v, input logic vv, input logic w);
    chk({tag, "_value"}, 32'(bus.value), 32'(v));
    chk({tag, "_valid"}, 32'(bus.value_valid), 32'(vv));
    chk({tag, "_wrap"}, 32'(bus.wrap), 32'(w));
  endtask

  initial begin
    bus.en = 0; bus.sync = 0; bus.tuning_word = '0; bus.shape = SH_SINE; bus.amp = 8'hFF;
    model_reset();

    // 1: reset, idle, sync to phase 0
    run(3);
    rst = 1'b1;
    run(2);
    chk_out("reset_idle", 12'h000, 1'b0, 1'b0);
    bus.sync = 1; tick(); bus.sync = 0;
    run(3);
    chk_out("sync_first", 12'h800, 1'b1, 1'b1);

    // 2: sine sweep, 4096 samples per period
    bus.tuning_word = 32'h0010_0000;
    bus.sync = 1; tick(); bus.sync = 0; bus.en = 1;
    run(3);    chk_out("sine_q0", 12'h800, 1'b1, 1'b1);
    run(1024); chk_out("sine_q1", 12'hFFF, 1'b1, 1'b0);
    run(1024); chk_out("sine_q2", 12'h7FF, 1'b1, 1'b0);
    run(1024); chk_out("sine_q3", 12'h000, 1'b1, 1'b0);
    run(1024); chk_out("sine_wrap", 12'h800, 1'b1, 1'b1);

    // 3: saw -> square requested mid-period
    bus.en = 0; bus.shape = SH_SAW; bus.tuning_word = 32'h1000_0000;
    bus.sync = 1; tick(); bus.sync = 0; bus.en = 1;
    run(4);
    bus.shape = SH_SQR;
    run(3); chk_out("saw_hold_4", 12'h400, 1'b1, 1'b0);
    run(9); chk_out("saw_hold_d", 12'hD00, 1'b1, 1'b0);
    run(3); chk_out("sqr_after_wrap", 12'hFFF, 1'b1, 1'b1);

    // 4: amplitude scaling on square
    bus.amp = 8'h7F;
    bus.sync = 1; tick(); bus.sync = 0;
    run(3); chk_out("amp7f_high", 12'hBFF, 1'b1, 1'b1);
    run(8); chk_out("amp7f_low", 12'h400, 1'b1, 1'b0);
    bus.amp = 8'h00;
    bus.sync = 1; tick(); bus.sync = 0;
    run(3); chk_out("amp00_high", 12'h807, 1'b1, 1'b1);
    run(8); chk_out("amp00_low", 12'h7F8, 1'b1, 1'b0);

    // 5: sync together with en mid-stream, then triangle, then zero tuning word
    run(5);
    bus.shape = SH_SINE; bus.amp = 8'hFF;
    bus.sync = 1; tick(); bus.sync = 0;
    run(3); chk_out("en_sync_phase0", 12'h800, 1'b1, 1'b1);
    run(1); chk_out("en_sync_next", 12'hB0F, 1'b1, 1'b0);
    bus.shape = SH_TRI; bus.tuning_word = 32'h0800_0000;
    bus.sync = 1; tick(); bus.sync = 0;
    run(7); chk_out("tri_quarter", 12'hA00, 1'b1, 1'b0);
    bus.tuning_word = 32'h0;
    bus.sync = 1; tick(); bus.sync = 0;
    run(3); chk_out("tw0_first", 12'h800, 1'b1, 1'b1);
    run(1); chk_out("tw0_hold1", 12'h800, 1'b1, 1'b0);
    run(4); chk_out("tw0_hold2", 12'h800, 1'b1, 1'b0);

    // 6: asynchronous reset between clock edges mid-stream
    bus.shape = SH_SINE; bus.tuning_word = 32'h0010_0000;
    bus.sync = 1; tick(); bus.sync = 0;
    run(300);
    #2 rst = 1'b0;
    #1 chk_out("async_rst", 12'h000, 1'b0, 1'b0);
    model_reset();
    run(2);
    rst = 1'b1; bus.en = 0; bus.amp = 8'hFF; bus.shape = SH_SINE;
    run(2);
    chk_out("resume_idle", 12'h000, 1'b0, 1'b0);
    bus.sync = 1; tick(); bus.sync = 0;
    run(3);
    chk_out("resume_sync", 12'h800, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
